systolic_tile_sequencer: RTL and testbench
==========================================

Name: systolic_tile_sequencer

Overview:
Run-level controller for the parametrised SYSTOLIC_ARRAY. Accepts a matrix job (M, K, N) and partitions the M x N output into PE-array-sized tiles. Issues one tile descriptor per tile over a valid/ready handshake and tracks tile completions with a bounded outstanding window. Raises a one-cycle finish pulse and reports total run cycles, replacing ad-hoc cycle counting in benches.

Parameters:
PE_ARRAY_NUM_ROWS, 4, tile height along M
PE_ARRAY_NUM_COLS, 4, tile width along N
MAX_M_SIZE_LOG2, 9, width of M size/index
MAX_K_SIZE_LOG2, 9, width of K size
MAX_N_SIZE_LOG2, 9, width of N size/index
MAX_OUTSTANDING, 2, max issued-but-not-completed tiles (>=1)
CYCLE_CNT_BWIDTH, 32, width of cycle counter

Ports:
CLK  in  1  clock
RSTn  in  1  reset, synchronous, active-low
START  in  1  job request; sampled only in IDLE
STALL  in  1  blocks tile issue while high
M_SIZE_in  in  MAX_M_SIZE_LOG2  rows of output
K_SIZE_in  in  MAX_K_SIZE_LOG2  reduction depth
N_SIZE_in  in  MAX_N_SIZE_LOG2  cols of output
TILE_VALID_out  out  1  descriptor valid
TILE_READY_in  in  1  array accepts descriptor
TILE_M_IDX_out  out  MAX_M_SIZE_LOG2  tile base row
TILE_N_IDX_out  out  MAX_N_SIZE_LOG2  tile base col
TILE_M_LEN_out  out  PE_ARRAY_NUM_ROWS_LOG2+1  valid rows in tile (1..ROWS)
TILE_N_LEN_out  out  PE_ARRAY_NUM_COLS_LOG2+1  valid cols in tile (1..COLS)
TILE_K_LEN_out  out  MAX_K_SIZE_LOG2  latched K
TILE_DONE_in  in  1  one pulse per completed tile
BUSY_out  out  1  job in progress
IS_FINISHED_out  out  1  one-cycle finish pulse
CYCLE_COUNT_out  out  CYCLE_CNT_BWIDTH  cycles of last/current job
ERR_out  out  1  sticky protocol error

Behaviour:
- Reset (RSTn low at CLK edge): state IDLE; all outputs 0; counters, latched sizes, ERR cleared. Reset mid-job abandons the job with no finish pulse.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: START=1 latches M/K/N, clears CYCLE_COUNT, sets BUSY. If any size is 0 -> DONE; else ISSUE with m_idx=n_idx=0. START outside IDLE ignored.
- ISSUE: TILE_VALID_out=1 iff !STALL and outstanding<MAX_OUTSTANDING. Descriptor is registered and stable while VALID && !READY. STALL rising after VALID is asserted does not drop VALID: once asserted, VALID holds until handshake.
- Handshake = VALID && READY at CLK edge: outstanding+1, advance n_idx += COLS; on n wrap (n_idx+COLS >= N) n_idx=0, m_idx += ROWS. Last tile handshake -> DRAIN.
- M_LEN = min(ROWS, M-m_idx); N_LEN = min(COLS, N-n_idx); K_LEN = latched K. Order: m outer, n inner.
- TILE_DONE_in: outstanding-1. Simultaneous handshake and done: outstanding unchanged. DONE while outstanding==0: ignored, ERR_out set (sticky until reset).
- DRAIN: wait outstanding==0 -> DONE.
- DONE: IS_FINISHED_out=1 for exactly one cycle, BUSY cleared, -> IDLE. START in the DONE cycle ignored.
- CYCLE_COUNT: increments each cycle while BUSY, saturating at all-ones; includes the DONE cycle; held in IDLE until next accepted START.
- Zero-size job: IS_FINISHED 1 cycle after START edge, CYCLE_COUNT=1, no tiles.

Optional Feature:
SYSTOLIC_SEQ_PERF_EN: defined -> adds outputs STALL_CYCLES_out and BACKPRESSURE_CYCLES_out (CYCLE_CNT_BWIDTH each). These count ISSUE cycles with STALL=1, and cycles with VALID && !READY, respectively. Both clear on START and saturate. Undefined -> ports and counters absent; all other behaviour identical.

Test Plan:
- M=K=N=16, ROWS=COLS=4, READY=1, DONE 5 cycles after each issue -> 16 tiles in order (0,0),(0,4),(0,8),(0,12),(4,0)..(12,12); all LEN=4, K_LEN=16; one IS_FINISHED pulse; CYCLE_COUNT matches bench counter.
- M=6, N=5, K=3 -> 4 tiles: (0,0) 4x4, (0,4) 4x1, (4,0) 2x4, (4,4) 2x1.
- M=0 -> no VALID, IS_FINISHED one cycle after START, CYCLE_COUNT=1.
- MAX_OUTSTANDING=2, DONE withheld -> VALID drops after 2 handshakes; one DONE pulse -> exactly one more issue.
- READY=0 for 3 cycles with STALL toggled -> descriptor and VALID stable; spurious DONE in IDLE -> ERR_out=1 and sticky.
- RSTn low mid-ISSUE -> next cycle all outputs 0, state IDLE, no IS_FINISHED; new START runs a clean job.

Source files
------------

// File: rtl/systolic_tile_sequencer.sv
// ---------------------------------------------------------------------------
// systolic_tile_sequencer
//
// Run-level controller for the parametrised systolic array. It accepts a
// matrix job (M x K x N) and walks the M x N output in PE-array-sized tiles,
// m outer and n inner. For each tile it offers one descriptor over a
// valid/ready handshake. It limits the number of issued-but-not-completed
// tiles to MAX_OUTSTANDING and raises a one-cycle finish pulse when the last
// tile has completed. It also reports the cycle count of the job.
//
// Optional build macro: SYSTOLIC_SEQ_PERF_EN
//   Defining it adds STALL_CYCLES_out and BACKPRESSURE_CYCLES_out.
//
// Ports
//   CLK, RSTn              clock; synchronous active-low reset
//   START                  job request, honoured only in IDLE
//   STALL                  blocks new descriptor offers while high
//   M/K/N_SIZE_in          job dimensions (latched on START)
//   TILE_VALID_out         descriptor offered
//   TILE_READY_in          array accepts descriptor
//   TILE_M/N_IDX_out       tile base row / column
//   TILE_M/N_LEN_out       valid rows / columns in tile (1..ROWS / 1..COLS)
//   TILE_K_LEN_out         latched reduction depth
//   TILE_DONE_in           one pulse per completed tile
//   BUSY_out               job in progress (ISSUE, DRAIN, DONE)
//   IS_FINISHED_out        one-cycle pulse in the DONE state
//   CYCLE_COUNT_out        busy cycles of the last/current job (saturating)
//   ERR_out                sticky: completion seen with nothing outstanding
//   STALL_CYCLES_out       (perf) ISSUE cycles with STALL high
//   BACKPRESSURE_CYCLES_out(perf) cycles with VALID high and READY low
// ---------------------------------------------------------------------------
module systolic_tile_sequencer #(
    parameter int PE_ARRAY_NUM_ROWS = 4,
    parameter int PE_ARRAY_NUM_COLS = 4,
    parameter int MAX_M_SIZE_LOG2   = 9,
    parameter int MAX_K_SIZE_LOG2   = 9,
    parameter int MAX_N_SIZE_LOG2   = 9,
    parameter int MAX_OUTSTANDING   = 2,
    parameter int CYCLE_CNT_BWIDTH  = 32,
    localparam int PE_ARRAY_NUM_ROWS_LOG2 = $clog2(PE_ARRAY_NUM_ROWS),
    localparam int PE_ARRAY_NUM_COLS_LOG2 = $clog2(PE_ARRAY_NUM_COLS)
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              START,
    input  logic                              STALL,
    input  logic [MAX_M_SIZE_LOG2-1:0]        M_SIZE_in,
    input  logic [MAX_K_SIZE_LOG2-1:0]        K_SIZE_in,
    input  logic [MAX_N_SIZE_LOG2-1:0]        N_SIZE_in,
    output logic                              TILE_VALID_out,
    input  logic                              TILE_READY_in,
    output logic [MAX_M_SIZE_LOG2-1:0]        TILE_M_IDX_out,
    output logic [MAX_N_SIZE_LOG2-1:0]        TILE_N_IDX_out,
    output logic [PE_ARRAY_NUM_ROWS_LOG2:0]   TILE_M_LEN_out,
    output logic [PE_ARRAY_NUM_COLS_LOG2:0]   TILE_N_LEN_out,
    output logic [MAX_K_SIZE_LOG2-1:0]        TILE_K_LEN_out,
    input  logic                              TILE_DONE_in,
    output logic                              BUSY_out,
    output logic                              IS_FINISHED_out,
    output logic [CYCLE_CNT_BWIDTH-1:0]       CYCLE_COUNT_out,
`ifdef SYSTOLIC_SEQ_PERF_EN
    output logic [CYCLE_CNT_BWIDTH-1:0]       STALL_CYCLES_out,
    output logic [CYCLE_CNT_BWIDTH-1:0]       BACKPRESSURE_CYCLES_out,
`endif
    output logic                              ERR_out
);

    localparam int MW  = MAX_M_SIZE_LOG2;
    localparam int KW  = MAX_K_SIZE_LOG2;
    localparam int NW  = MAX_N_SIZE_LOG2;
    localparam int MW1 = MW + 1;
    localparam int NW1 = NW + 1;
    localparam int RLW = PE_ARRAY_NUM_ROWS_LOG2 + 1;
    localparam int CLW = PE_ARRAY_NUM_COLS_LOG2 + 1;
    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW  = CYCLE_CNT_BWIDTH;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          r_state, w_state_nxt;
    logic [MW-1:0]   r_m_size, r_m_idx;
    logic [KW-1:0]   r_k_size;
    logic [NW-1:0]   r_n_size, r_n_idx;
    logic [RLW-1:0]  r_m_len;
    logic [CLW-1:0]  r_n_len;
    logic [OW-1:0]   r_out_cnt;
    logic            r_vld_hold;
    logic            r_err;
    logic [CW-1:0]   r_cycle;

    logic            w_valid, w_hs, w_start, w_zero;
    logic            w_done_ok, w_err_evt;
    logic [MW1-1:0]  w_m_next;
    logic [NW1-1:0]  w_n_next;
    logic            w_n_wrap, w_m_last, w_last;
    logic [MW-1:0]   w_m_idx_nxt;
    logic [NW-1:0]   w_n_idx_nxt;

    // Tile extent along M: rows remaining from idx, clipped to the array height.
    function automatic logic [RLW-1:0] clip_m(input logic [MW-1:0] size,
                                              input logic [MW-1:0] idx);
        logic [MW-1:0] rem;
        rem = size - idx;
        if (size <= idx) return '0;
        if (rem >= MW'(PE_ARRAY_NUM_ROWS)) return RLW'(PE_ARRAY_NUM_ROWS);
        return RLW'(rem);
    endfunction

    // Tile extent along N: columns remaining from idx, clipped to the array width.
    function automatic logic [CLW-1:0] clip_n(input logic [NW-1:0] size,
                                              input logic [NW-1:0] idx);
        logic [NW-1:0] rem;
        rem = size - idx;
        if (size <= idx) return '0;
        if (rem >= NW'(PE_ARRAY_NUM_COLS)) return CLW'(PE_ARRAY_NUM_COLS);
        return CLW'(rem);
    endfunction

    // Once offered, a descriptor stays valid until accepted even if STALL
    // rises or the window fills; r_vld_hold carries that commitment.
    assign w_valid   = (r_state == S_ISSUE) &&
                       (r_vld_hold || (!STALL && (r_out_cnt < OW'(MAX_OUTSTANDING))));
    assign w_hs      = w_valid && TILE_READY_in;
    assign w_start   = (r_state == S_IDLE) && START;
    assign w_zero    = (M_SIZE_in == '0) || (K_SIZE_in == '0) || (N_SIZE_in == '0);
    assign w_done_ok = TILE_DONE_in && (r_out_cnt != '0);
    assign w_err_evt = TILE_DONE_in && (r_out_cnt == '0);

    // One extra bit so idx + tile size cannot wrap near the top of the range.
    assign w_m_next    = {1'b0, r_m_idx} + MW1'(PE_ARRAY_NUM_ROWS);
    assign w_n_next    = {1'b0, r_n_idx} + NW1'(PE_ARRAY_NUM_COLS);
    assign w_n_wrap    = (w_n_next >= {1'b0, r_n_size});
    assign w_m_last    = (w_m_next >= {1'b0, r_m_size});
    assign w_last      = w_n_wrap && w_m_last;
    assign w_m_idx_nxt = w_n_wrap ? w_m_next[MW-1:0] : r_m_idx;
    assign w_n_idx_nxt = w_n_wrap ? '0 : w_n_next[NW-1:0];

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (START) w_state_nxt = w_zero ? S_DONE : S_ISSUE;
            S_ISSUE: if (w_hs && w_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_out_cnt == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_m_size   <= '0;
            r_k_size   <= '0;
            r_n_size   <= '0;
            r_m_idx    <= '0;
            r_n_idx    <= '0;
            r_m_len    <= '0;
            r_n_len    <= '0;
            r_out_cnt  <= '0;
            r_vld_hold <= 1'b0;
            r_err      <= 1'b0;
            r_cycle    <= '0;
        end else begin
            r_vld_hold <= w_valid && !TILE_READY_in;
            if (w_err_evt) r_err <= 1'b1;

            // Issue and completion in the same cycle cancel out.
            case ({w_hs, w_done_ok})
                2'b10:   r_out_cnt <= r_out_cnt + OW'(1);
                2'b01:   r_out_cnt <= r_out_cnt - OW'(1);
                default: r_out_cnt <= r_out_cnt;
            endcase

            if (w_start) begin
                r_m_size <= M_SIZE_in;
                r_k_size <= K_SIZE_in;
                r_n_size <= N_SIZE_in;
                r_m_idx  <= '0;
                r_n_idx  <= '0;
                r_m_len  <= clip_m(M_SIZE_in, '0);
                r_n_len  <= clip_n(N_SIZE_in, '0);
                r_cycle  <= '0;
            end else begin
                if (w_hs) begin
                    r_m_idx <= w_m_idx_nxt;
                    r_n_idx <= w_n_idx_nxt;
                    r_m_len <= clip_m(r_m_size, w_m_idx_nxt);
                    r_n_len <= clip_n(r_n_size, w_n_idx_nxt);
                end
                if ((r_state != S_IDLE) && (r_cycle != '1)) r_cycle <= r_cycle + CW'(1);
            end
        end
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [CW-1:0] r_stall_cyc, r_bp_cyc;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_stall_cyc <= '0;
            r_bp_cyc    <= '0;
        end else if (w_start) begin
            r_stall_cyc <= '0;
            r_bp_cyc    <= '0;
        end else begin
            if ((r_state == S_ISSUE) && STALL && (r_stall_cyc != '1))
                r_stall_cyc <= r_stall_cyc + CW'(1);
            if (w_valid && !TILE_READY_in && (r_bp_cyc != '1))
                r_bp_cyc <= r_bp_cyc + CW'(1);
        end
    end

    assign STALL_CYCLES_out        = r_stall_cyc;
    assign BACKPRESSURE_CYCLES_out = r_bp_cyc;
`endif

    assign TILE_VALID_out  = w_valid;
    assign TILE_M_IDX_out  = r_m_idx;
    assign TILE_N_IDX_out  = r_n_idx;
    assign TILE_M_LEN_out  = r_m_len;
    assign TILE_N_LEN_out  = r_n_len;
    assign TILE_K_LEN_out  = r_k_size;
    assign BUSY_out        = (r_state != S_IDLE);
    assign IS_FINISHED_out = (r_state == S_DONE);
    assign CYCLE_COUNT_out = r_cycle;
    assign ERR_out         = r_err;

endmodule

// File: tb/tb_systolic_tile_sequencer.sv
// ---------------------------------------------------------------------------
// Directed testbench for systolic_tile_sequencer (default parameters:
// 4x4 array, 9-bit sizes, two outstanding tiles, 32-bit cycle counter).
// ---------------------------------------------------------------------------
module tb_systolic_tile_sequencer;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        START = 1'b0;
    logic        STALL = 1'b0;
    logic [8:0]  M_SIZE_in = '0;
    logic [8:0]  K_SIZE_in = '0;
    logic [8:0]  N_SIZE_in = '0;
    logic        TILE_READY_in = 1'b1;
    logic        TILE_DONE_in;
    logic        TILE_VALID_out;
    logic [8:0]  TILE_M_IDX_out, TILE_N_IDX_out, TILE_K_LEN_out;
    logic [2:0]  TILE_M_LEN_out, TILE_N_LEN_out;
    logic        BUSY_out, IS_FINISHED_out, ERR_out;
    logic [31:0] CYCLE_COUNT_out;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [31:0] STALL_CYCLES_out, BACKPRESSURE_CYCLES_out;
`endif

    systolic_tile_sequencer dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .STALL(STALL),
        .M_SIZE_in(M_SIZE_in), .K_SIZE_in(K_SIZE_in), .N_SIZE_in(N_SIZE_in),
        .TILE_VALID_out(TILE_VALID_out), .TILE_READY_in(TILE_READY_in),
        .TILE_M_IDX_out(TILE_M_IDX_out), .TILE_N_IDX_out(TILE_N_IDX_out),
        .TILE_M_LEN_out(TILE_M_LEN_out), .TILE_N_LEN_out(TILE_N_LEN_out),
        .TILE_K_LEN_out(TILE_K_LEN_out), .TILE_DONE_in(TILE_DONE_in),
        .BUSY_out(BUSY_out), .IS_FINISHED_out(IS_FINISHED_out),
        .CYCLE_COUNT_out(CYCLE_COUNT_out),
`ifdef SYSTOLIC_SEQ_PERF_EN
        .STALL_CYCLES_out(STALL_CYCLES_out),
        .BACKPRESSURE_CYCLES_out(BACKPRESSURE_CYCLES_out),
`endif
        .ERR_out(ERR_out)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] desc(input int m, input int n, input int ml,
                                         input int nl, input int kl);
        return {16'(m), 16'(n), 8'(ml), 8'(nl), 16'(kl)};
    endfunction

    logic [63:0] w_desc;
    assign w_desc = {7'b0, TILE_M_IDX_out, 7'b0, TILE_N_IDX_out,
                     5'b0, TILE_M_LEN_out, 5'b0, TILE_N_LEN_out, 7'b0, TILE_K_LEN_out};

    // Monitor and tile-completion responder (completion 5 cycles after accept).
    logic [63:0] tlog[$];
    int          busy_cnt = 0;
    int          fin_cnt  = 0;
    logic [7:0]  pipe = '0;
    logic        done_auto = 1'b0;
    logic        done_man  = 1'b0;
    logic        auto_en   = 1'b0;
    assign TILE_DONE_in = done_auto | done_man;

    always @(negedge CLK) begin
        if (!RSTn) begin
            pipe      = '0;
            done_auto = 1'b0;
        end else begin
            if (TILE_VALID_out && TILE_READY_in) tlog.push_back(w_desc);
            if (BUSY_out) busy_cnt++;
            if (IS_FINISHED_out) fin_cnt++;
            pipe      = {pipe[6:0], TILE_VALID_out && TILE_READY_in && auto_en};
            done_auto = pipe[4];
        end
    end

    logic [63:0] exp_q[$];

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic start_job(input int m, input int k, input int n);
        M_SIZE_in = 9'(m);
        K_SIZE_in = 9'(k);
        N_SIZE_in = 9'(n);
        START = 1'b1;
        tick(1);
        START = 1'b0;
    endtask

    task automatic pulse_done();
        done_man = 1'b1;
        tick(1);
        done_man = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge CLK);
            if (IS_FINISHED_out) seen = 1'b1;
        end
        check_eq({tag, "_finished"}, 64'(seen), 64'd1);
        tick(1);
    endtask

    task automatic check_tiles(input string tag, input int base);
        check_eq({tag, "_ntiles"}, 64'(tlog.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < tlog.size())
                check_eq($sformatf("%s_tile%0d", tag, i), tlog[base + i], exp_q[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, 64'(TILE_VALID_out), 64'd0);
        check_eq({tag, "_busy"},  64'(BUSY_out), 64'd0);
        check_eq({tag, "_fin"},   64'(IS_FINISHED_out), 64'd0);
        check_eq({tag, "_cycle"}, 64'(CYCLE_COUNT_out), 64'd0);
        check_eq({tag, "_err"},   64'(ERR_out), 64'd0);
        check_eq({tag, "_desc"},  w_desc, 64'd0);
    endtask

    initial begin
        int tb, bb, fb;
        int stall_pat[3];
        stall_pat = '{1, 0, 1};

        // Reset state
        tick(3);
        check_reset_outputs("rst");
        RSTn = 1'b1;
        tick(1);

        // 16x16x16: sixteen full tiles, m outer, n inner
        auto_en = 1'b1;
        exp_q.delete();
        for (int m = 0; m < 16; m += 4)
            for (int n = 0; n < 16; n += 4)
                exp_q.push_back(desc(m, n, 4, 4, 16));
        tb = tlog.size(); bb = busy_cnt; fb = fin_cnt;
        start_job(16, 16, 16);
        wait_finish("j16", 600);
        check_tiles("j16", tb);
        check_eq("j16_fin_pulses", 64'(fin_cnt - fb), 64'd1);
        check_eq("j16_cycles", 64'(CYCLE_COUNT_out), 64'(busy_cnt - bb));
        check_eq("j16_busy_after", 64'(BUSY_out), 64'd0);
        check_eq("j16_err", 64'(ERR_out), 64'd0);

        // 6x3x5: partial tiles on both edges
        exp_q.delete();
        exp_q.push_back(desc(0, 0, 4, 4, 3));
        exp_q.push_back(desc(0, 4, 4, 1, 3));
        exp_q.push_back(desc(4, 0, 2, 4, 3));
        exp_q.push_back(desc(4, 4, 2, 1, 3));
        tb = tlog.size(); bb = busy_cnt;
        start_job(6, 3, 5);
        wait_finish("j6x5", 300);
        check_tiles("j6x5", tb);
        check_eq("j6x5_cycles", 64'(CYCLE_COUNT_out), 64'(busy_cnt - bb));

        // Zero-size job
        tb = tlog.size();
        start_job(0, 5, 5);
        check_eq("zero_fin", 64'(IS_FINISHED_out), 64'd1);
        check_eq("zero_valid", 64'(TILE_VALID_out), 64'd0);
        tick(1);
        check_eq("zero_fin_drop", 64'(IS_FINISHED_out), 64'd0);
        check_eq("zero_busy", 64'(BUSY_out), 64'd0);
        check_eq("zero_cycles", 64'(CYCLE_COUNT_out), 64'd1);
        check_eq("zero_ntiles", 64'(tlog.size() - tb), 64'd0);

        // Outstanding window with completions withheld
        auto_en = 1'b0;
        exp_q.delete();
        exp_q.push_back(desc(0, 0, 4, 4, 4));
        exp_q.push_back(desc(0, 4, 4, 4, 4));
        exp_q.push_back(desc(4, 0, 4, 4, 4));
        exp_q.push_back(desc(4, 4, 4, 4, 4));
        tb = tlog.size();
        start_job(8, 4, 8);
        tick(4);
        check_eq("win_two_issued", 64'(tlog.size() - tb), 64'd2);
        check_eq("win_valid_low", 64'(TILE_VALID_out), 64'd0);
        pulse_done();
        tick(3);
        check_eq("win_one_more", 64'(tlog.size() - tb), 64'd3);
        check_eq("win_valid_low2", 64'(TILE_VALID_out), 64'd0);
        pulse_done();
        tick(2);
        check_eq("win_all_issued", 64'(tlog.size() - tb), 64'd4);
        check_eq("win_drain_busy", 64'(BUSY_out), 64'd1);
        check_eq("win_drain_fin", 64'(IS_FINISHED_out), 64'd0);
        pulse_done();
        pulse_done();
        wait_finish("win", 20);
        check_tiles("win", tb);
        check_eq("win_err", 64'(ERR_out), 64'd0);

        // Backpressure with STALL toggling: descriptor must hold
        TILE_READY_in = 1'b0;
        STALL = 1'b0;
        tb = tlog.size();
        start_job(4, 2, 8);
        check_eq("bp_valid0", 64'(TILE_VALID_out), 64'd1);
        check_eq("bp_desc0", w_desc, desc(0, 0, 4, 4, 2));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            STALL = stall_pat[i][0];
            #1;
            check_eq($sformatf("bp_valid_hold%0d", i), 64'(TILE_VALID_out), 64'd1);
            check_eq($sformatf("bp_desc_hold%0d", i), w_desc, desc(0, 0, 4, 4, 2));
        end
        TILE_READY_in = 1'b1;
        tick(1);
        check_eq("bp_accepted", 64'(tlog.size() - tb), 64'd1);
        check_eq("bp_stall_blocks", 64'(TILE_VALID_out), 64'd0);
        STALL = 1'b0;
        #1;
        check_eq("bp_valid_next", 64'(TILE_VALID_out), 64'd1);
        check_eq("bp_desc_next", w_desc, desc(0, 4, 4, 4, 2));
        tick(1);
        check_eq("bp_all_issued", 64'(tlog.size() - tb), 64'd2);
`ifdef SYSTOLIC_SEQ_PERF_EN
        check_eq("perf_stall", 64'(STALL_CYCLES_out), 64'd2);
        check_eq("perf_bp", 64'(BACKPRESSURE_CYCLES_out), 64'd3);
`endif
        pulse_done();
        pulse_done();
        wait_finish("bp", 20);
        check_eq("bp_err_clean", 64'(ERR_out), 64'd0);

        // Spurious completion while idle sets sticky error
        pulse_done();
        check_eq("err_set", 64'(ERR_out), 64'd1);
        tick(3);
        check_eq("err_sticky", 64'(ERR_out), 64'd1);

        // Reset in the middle of a job
        auto_en = 1'b1;
        start_job(16, 16, 16);
        tick(6);
        check_eq("mid_busy_before", 64'(BUSY_out), 64'd1);
        fb = fin_cnt;
        RSTn = 1'b0;
        tick(1);
        check_reset_outputs("midrst");
        RSTn = 1'b1;
        tick(3);
        check_eq("midrst_no_fin", 64'(fin_cnt - fb), 64'd0);
        check_eq("midrst_idle", 64'(BUSY_out), 64'd0);

        // Clean job after the abandoned one
        exp_q.delete();
        exp_q.push_back(desc(0, 0, 4, 4, 3));
        exp_q.push_back(desc(0, 4, 4, 1, 3));
        exp_q.push_back(desc(4, 0, 2, 4, 3));
        exp_q.push_back(desc(4, 4, 2, 1, 3));
        tb = tlog.size(); bb = busy_cnt; fb = fin_cnt;
        start_job(6, 3, 5);
        wait_finish("post", 300);
        check_tiles("post", tb);
        check_eq("post_fin_pulses", 64'(fin_cnt - fb), 64'd1);
        check_eq("post_cycles", 64'(CYCLE_COUNT_out), 64'(busy_cnt - bb));
        check_eq("post_err", 64'(ERR_out), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
